dcache_ctrl: RTL
================

// Module: dcache_ctrl
// PURPOSE
//   Controller sequencing the 2-way, 16-set, 256-bit-line data-cache SRAM between the CPU load/store port
//   and the line-wide main-memory port. Resolves hits in one cycle, stalls the CPU on miss, writes back
//   dirty victims, refills the line, then retries the lookup. Word merge for stores is done here.
// PARAMETERS
//   ADDR_W   32   CPU/memory byte-address width
//   WORD_W   32   CPU data word width
//   LINE_W   256  cache line width (32 bytes, 8 words)
//   INDEX_W  4    set index width (16 sets)
//   TAG_W    23   address tag width; SRAM tag entry = {valid, dirty, tag} = TAG_W+2 bits
// PORTS
//   clk_i         in   1        clock
//   rst_i         in   1        reset, asynchronous, active-high
//   cpu_req_i     in   1        CPU access valid; addr/data/write held stable while cpu_stall_o=1
//   cpu_write_i   in   1        1=store, 0=load
//   cpu_addr_i    in   ADDR_W   byte address: tag=[31:9], index=[8:5], word=[4:2]
//   cpu_data_i    in   WORD_W   store data
//   cpu_data_o    out  WORD_W   load data (valid when cpu_req_i & ~cpu_stall_o & ~cpu_write_i)
//   cpu_stall_o   out  1        CPU must hold request
//   sram_enable_o out  1        SRAM access enable
//   sram_write_o  out  1        SRAM write strobe
//   sram_addr_o   out  INDEX_W  set index (always cpu_addr_i[8:5])
//   sram_tag_o    out  TAG_W+2  {valid,dirty,tag}; dirty=1 -> write-hit update, dirty=0 -> refill into LRU way
//   sram_data_o   out  LINE_W   line to write
//   sram_tag_i    in   TAG_W+2  hit way tag on hit, else LRU victim tag
//   sram_data_i   in   LINE_W   hit way line on hit, else LRU victim line
//   sram_hit_i    in   1        combinational hit for cpu tag
//   mem_enable_o  out  1        memory request; held until mem_ack_i
//   mem_write_o   out  1        1=writeback, 0=refill read
//   mem_addr_o    out  ADDR_W   line-aligned address (low 5 bits zero)
//   mem_data_o    out  LINE_W   writeback line
//   mem_data_i    in   LINE_W   refill line, valid only in mem_ack_i cycle
//   mem_ack_i     in   1        one-cycle completion pulse
// BEHAVIOUR
//   States: IDLE, MISS, WRITEBACK, REFILL. Reset -> IDLE; all outputs 0 (stall 0, mem_enable 0).
//   IDLE: cpu_req_i & sram_hit_i: load -> cpu_data_o = sram_data_i[32*w+31:32*w], stall 0, 0 latency.
//     store -> same cycle sram_enable/write=1, tag={1,1,tag}, data=sram_data_i with word w replaced; stall 0.
//   IDLE: cpu_req_i & ~sram_hit_i -> cpu_stall_o=1 combinationally same cycle, next MISS.
//   MISS (1 cycle): latch victim tag/line into wb buffer. victim valid&dirty -> WRITEBACK, else REFILL.
//   WRITEBACK: mem_enable=1, write=1, addr={victim tag,index,5'b0}, data=wb buffer; on ack -> REFILL.
//   REFILL: mem_enable=1, write=0, addr={cpu tag,index,5'b0}; on ack: same cycle SRAM write
//     tag={1,0,tag}, data=mem_data_i (SRAM flips LRU) -> IDLE; lookup retried, now hits, stall drops.
//   Stall stays 1 in MISS/WRITEBACK/REFILL; mem_enable deasserts the cycle after ack.
//   Write miss: write-allocate; refilled clean, store merged on retry hit (line becomes dirty).
//   mem_ack_i in IDLE/MISS ignored. cpu_req_i=0 in IDLE: no SRAM write, stall 0.
//   rst_i mid-transaction: immediate IDLE, mem_enable drops, wb buffer cleared; memory must abort.
// CONFIGURATION
//   DCACHE_PERF_CNT_EN defined: adds outputs hit_cnt_o, miss_cnt_o, wb_cnt_o (32 bit each, reset 0,
//     saturating at all-ones). hit counts IDLE hits incl. retry hits; miss counts IDLE->MISS;
//     wb counts WRITEBACK acks. Undefined: ports and counters absent; otherwise identical behaviour.
// STRUCTURE
//   dcache_pkg: state enum, INDEX/TAG/OFFSET bit positions, VALID_BIT=24, DIRTY_BIT=23 constants.
//   Sub-module dcache_word_merge: combinational word select (load) and word replace (store).
// TESTING
//   Cold load 0x0000_0040, ack after 3 cycles -> REFILL addr 0x40, stall 5 cycles, then data = word 0.
//   Load hit same line word 3 -> cpu_data_o=line[127:96], stall 0, no mem_enable.
//   Store 0xDEADBEEF to 0x44 hit -> SRAM write tag dirty=1, word1 replaced, other 7 words unchanged.
//   Fill both ways of set 2 dirty, access third tag -> WRITEBACK addr of LRU tag, then REFILL, then hit.
//   Assert rst_i during WRITEBACK -> state IDLE, mem_enable_o=0, stall 0 next edge.
//   Spurious mem_ack_i in IDLE with no miss -> no state change, no SRAM write.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the 2-way, 16-set data-cache controller:
// geometry, address field positions, tag-entry bit positions and FSM states.
package dcache_pkg;

  localparam int DC_ADDR_W   = 32;
  localparam int DC_WORD_W   = 32;
  localparam int DC_LINE_W   = 256;
  localparam int DC_INDEX_W  = 4;
  localparam int DC_TAG_W    = 23;
  localparam int DC_OFFSET_W = 5;
  localparam int DC_WSEL_W   = 3;
  localparam int DC_ENTRY_W  = DC_TAG_W + 2;

  localparam int DC_TAG_MSB   = 31;
  localparam int DC_TAG_LSB   = 9;
  localparam int DC_INDEX_MSB = 8;
  localparam int DC_INDEX_LSB = 5;
  localparam int DC_WORD_MSB  = 4;
  localparam int DC_WORD_LSB  = 2;

  localparam int VALID_BIT = 24;
  localparam int DIRTY_BIT = 23;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_MISS      = 2'd1;
  localparam state_t ST_WRITEBACK = 2'd2;
  localparam state_t ST_REFILL    = 2'd3;

  function automatic logic [DC_ENTRY_W-1:0] make_tag(input logic valid,
                                                     input logic dirty,
                                                     input logic [DC_TAG_W-1:0] tag);
    return {valid, dirty, tag};
  endfunction

endpackage

// File: rtl/dcache_word_merge.sv
// Word lane handling for a 256-bit cache line: extracts the addressed word
// for loads and produces the line with that word replaced for stores.
module dcache_word_merge
  import dcache_pkg::*;
(
  input  logic [DC_LINE_W-1:0] line_i,
  input  logic [DC_WSEL_W-1:0] word_sel_i,
  input  logic [DC_WORD_W-1:0] store_word_i,
  output logic [DC_WORD_W-1:0] load_word_o,
  output logic [DC_LINE_W-1:0] merged_line_o
);

  logic [7:0] bit_base;

  assign bit_base = {word_sel_i, 5'b00000};

  // Select the addressed word and build the store-merged line
  always_comb begin
    load_word_o   = line_i[bit_base +: DC_WORD_W];
    merged_line_o = line_i;
    merged_line_o[bit_base +: DC_WORD_W] = store_word_i;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Data-cache controller: single-cycle hits, stall on miss, dirty-victim
// writeback, line refill, then retry of the original lookup.
// Optional performance counters are enabled with `define DCACHE_PERF_CNT_EN.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W  = DC_ADDR_W,
  parameter int WORD_W  = DC_WORD_W,
  parameter int LINE_W  = DC_LINE_W,
  parameter int INDEX_W = DC_INDEX_W,
  parameter int TAG_W   = DC_TAG_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cpu_req_i,
  input  logic                cpu_write_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [WORD_W-1:0]   cpu_data_i,
  output logic [WORD_W-1:0]   cpu_data_o,
  output logic                cpu_stall_o,
  output logic                sram_enable_o,
  output logic                sram_write_o,
  output logic [INDEX_W-1:0]  sram_addr_o,
  output logic [TAG_W+1:0]    sram_tag_o,
  output logic [LINE_W-1:0]   sram_data_o,
  input  logic [TAG_W+1:0]    sram_tag_i,
  input  logic [LINE_W-1:0]   sram_data_i,
  input  logic                sram_hit_i,
  output logic                mem_enable_o,
  output logic                mem_write_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [LINE_W-1:0]   mem_data_o,
  input  logic [LINE_W-1:0]   mem_data_i,
  input  logic                mem_ack_i
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]         hit_cnt_o,
  output logic [31:0]         miss_cnt_o,
  output logic [31:0]         wb_cnt_o
`endif
);

  state_t state_q, state_d;

  logic [TAG_W-1:0]   wb_tag_q;
  logic [LINE_W-1:0]  wb_line_q;

  logic [TAG_W-1:0]   cpu_tag;
  logic [INDEX_W-1:0] cpu_index;
  logic [2:0]         cpu_word;
  logic               unused_addr_bits;

  logic               lookup_hit;
  logic               lookup_miss;
  logic               victim_dirty;
  logic               wb_done;
  logic               refill_done;

  logic [WORD_W-1:0]  hit_word;
  logic [LINE_W-1:0]  merged_line;

  assign cpu_tag          = cpu_addr_i[DC_TAG_MSB:DC_TAG_LSB];
  assign cpu_index        = cpu_addr_i[DC_INDEX_MSB:DC_INDEX_LSB];
  assign cpu_word         = cpu_addr_i[DC_WORD_MSB:DC_WORD_LSB];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign lookup_hit   = (state_q == ST_IDLE) && cpu_req_i && sram_hit_i;
  assign lookup_miss  = (state_q == ST_IDLE) && cpu_req_i && !sram_hit_i;
  assign victim_dirty = sram_tag_i[VALID_BIT] && sram_tag_i[DIRTY_BIT];
  assign wb_done      = (state_q == ST_WRITEBACK) && mem_ack_i;
  assign refill_done  = (state_q == ST_REFILL) && mem_ack_i;

  // The SRAM set index always follows the CPU address so the retry lookup needs no extra cycle
  assign sram_addr_o = cpu_index;

  dcache_word_merge u_word_merge (
    .line_i        (sram_data_i),
    .word_sel_i    (cpu_word),
    .store_word_i  (cpu_data_i),
    .load_word_o   (hit_word),
    .merged_line_o (merged_line)
  );

  // Next-state logic; ack pulses outside WRITEBACK/REFILL are ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (lookup_miss) state_d = ST_MISS;
      ST_MISS:      state_d = victim_dirty ? ST_WRITEBACK : ST_REFILL;
      ST_WRITEBACK: if (mem_ack_i) state_d = ST_REFILL;
      ST_REFILL:    if (mem_ack_i) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // State register and victim buffer captured in MISS; reset aborts any transaction
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      wb_tag_q  <= '0;
      wb_line_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_MISS) begin
        wb_tag_q  <= sram_tag_i[TAG_W-1:0];
        wb_line_q <= sram_data_i;
      end
    end
  end

  // Output decode: hit service in IDLE, memory handshakes in WRITEBACK/REFILL
  always_comb begin
    cpu_data_o    = '0;
    cpu_stall_o   = 1'b0;
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;
    sram_tag_o    = '0;
    sram_data_o   = '0;
    mem_enable_o  = 1'b0;
    mem_write_o   = 1'b0;
    mem_addr_o    = '0;
    mem_data_o    = '0;
    case (state_q)
      ST_IDLE: begin
        sram_enable_o = cpu_req_i;
        cpu_stall_o   = lookup_miss;
        if (lookup_hit && cpu_write_i) begin
          sram_write_o = 1'b1;
          sram_tag_o   = make_tag(1'b1, 1'b1, cpu_tag);
          sram_data_o  = merged_line;
        end
        if (lookup_hit && !cpu_write_i) begin
          cpu_data_o = hit_word;
        end
      end
      ST_MISS: begin
        cpu_stall_o = 1'b1;
      end
      ST_WRITEBACK: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {wb_tag_q, cpu_index, {DC_OFFSET_W{1'b0}}};
        mem_data_o   = wb_line_q;
      end
      ST_REFILL: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {cpu_tag, cpu_index, {DC_OFFSET_W{1'b0}}};
        if (refill_done) begin
          sram_enable_o = 1'b1;
          sram_write_o  = 1'b1;
          sram_tag_o    = make_tag(1'b1, 1'b0, cpu_tag);
          sram_data_o   = mem_data_i;
        end
      end
      default: begin
        cpu_stall_o = 1'b0;
      end
    endcase
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic [31:0] wb_cnt_q;

  // Saturating event counters for hits (including retry hits), misses and writebacks
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (lookup_hit && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (lookup_miss && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (wb_done && (wb_cnt_q != '1))       wb_cnt_q   <= wb_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
  assign wb_cnt_o   = wb_cnt_q;
`else
  logic unused_wb_done;
  assign unused_wb_done = wb_done;
`endif

endmodule
